// File: rtl/ycbcr_video_source_pkg.sv
// Shared encodings and constants for the synthetic SAA7111A-style YCbCr video source.
package ycbcr_video_source_pkg;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_FIXED = 2'd2,
      PAT_CHECK = 2'd3
   } pattern_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } src_state_e;

   typedef struct packed {
      logic href;
      logic vref;
      logic odd;
      logic fs;
   } timing_t;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   localparam logic [15:0] BLACK_YC = 16'h1080;

   localparam logic signed [17:0] K_YR  =  18'sd66;
   localparam logic signed [17:0] K_YG  =  18'sd129;
   localparam logic signed [17:0] K_YB  =  18'sd25;
   localparam logic signed [17:0] K_BR  = -18'sd38;
   localparam logic signed [17:0] K_BG  = -18'sd74;
   localparam logic signed [17:0] K_BB  =  18'sd112;
   localparam logic signed [17:0] K_RR  =  18'sd112;
   localparam logic signed [17:0] K_RG  = -18'sd94;
   localparam logic signed [17:0] K_RB  = -18'sd18;
   localparam logic signed [17:0] K_RND =  18'sd128;
   localparam logic signed [17:0] Y_OFS =  18'sd16;
   localparam logic signed [17:0] C_OFS =  18'sd128;

   function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

   function automatic logic [7:0] clamp8(input logic signed [17:0] v);
      if (v < 18'sd0)
         return 8'd0;
      else if (v > 18'sd255)
         return 8'd255;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/ycbcr_video_source_rgb565_to_ycbcr.sv
// One-cycle registered RGB565 to YCbCr (BT.601 studio range) converter with output clamping.
module rgb565_to_ycbcr
   import ycbcr_video_source_pkg::*;
(
   input  logic        clk_llc2,
   input  logic        resetx,
   input  logic [15:0] rgb_i,
   output logic [7:0]  y_o,
   output logic [7:0]  cb_o,
   output logic [7:0]  cr_o
);

   logic [7:0]         r8, g8, b8;
   logic signed [17:0] r_s, g_s, b_s;
   logic signed [17:0] y_sum, cb_sum, cr_sum;
   logic [7:0]         y_d, cb_d, cr_d;
   logic [7:0]         y_q, cb_q, cr_q;

   always_comb begin
      r8 = {rgb_i[15:11], rgb_i[15:13]};
      g8 = {rgb_i[10:5],  rgb_i[10:9]};
      b8 = {rgb_i[4:0],   rgb_i[4:2]};
      r_s = $signed({10'd0, r8});
      g_s = $signed({10'd0, g8});
      b_s = $signed({10'd0, b8});
      // All operands signed, so >>> floors negative chroma sums
      y_sum  = ((K_YR * r_s + K_YG * g_s + K_YB * b_s + K_RND) >>> 8) + Y_OFS;
      cb_sum = ((K_BR * r_s + K_BG * g_s + K_BB * b_s + K_RND) >>> 8) + C_OFS;
      cr_sum = ((K_RR * r_s + K_RG * g_s + K_RB * b_s + K_RND) >>> 8) + C_OFS;
      y_d  = clamp8(y_sum);
      cb_d = clamp8(cb_sum);
      cr_d = clamp8(cr_sum);
   end

   always_ff @(posedge clk_llc2 or negedge resetx) begin
      if (!resetx) begin
         y_q  <= 8'd16;
         cb_q <= 8'd128;
         cr_q <= 8'd128;
      end else begin
         y_q  <= y_d;
         cb_q <= cb_d;
         cr_q <= cr_d;
      end
   end

   assign y_o  = y_q;
   assign cb_o = cb_q;
   assign cr_o = cr_q;

endmodule

// File: rtl/ycbcr_video_source.sv
// Synthetic interlaced YCbCr 4:2:2 video transmitter: field timing, test patterns, 3-stage pixel pipe.
//   state   | meaning
//   ST_IDLE | counters parked at 0, odd field armed, outputs blanked
//   ST_RUN  | counting; leaves only at a field wrap with enable low
module ycbcr_video_source
   import ycbcr_video_source_pkg::*;
#(
   parameter int H_TOTAL  = 858,
   parameter int H_ACTIVE = 720,
   parameter int V_TOTAL  = 262,
   parameter int V_ACTIVE = 240,
   parameter int BAR_W    = 90
) (
   input  logic        clk_llc2,
   input  logic        resetx,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [15:0] fixed_rgb,
   output logic        href,
   output logic        vref,
   output logic        odd,
   output logic [15:0] vpo,
   output logic        frame_start
);

   localparam int HW = 10;
   localparam int VW = 9;

   src_state_e    state_q, state_d;
   logic          running;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          odd_field_q, odd_field_d;
   logic          h_wrap, v_wrap, boundary;
   pattern_e      pat_q;
   logic [15:0]   fix_q;

   logic [HW-1:0] bar_idx;
   logic [2:0]    bar_sel;
   logic [7:0]    ramp_g;
   logic [15:0]   rgb0;
   timing_t       tim0, tim1_q, tim2_q, tim3_q;
   logic          act0, act1_q, act2_q;
   logic          x0_1_q, x0_2_q;
   logic [15:0]   rgb1_q;
   logic [7:0]    y2, cb2, cr2;
   logic [7:0]    cr_held_q, cr_held_d;
   logic [15:0]   vpo_q, vpo_d;

   assign h_wrap   = (h_cnt_q == HW'(H_TOTAL - 1));
   assign v_wrap   = h_wrap && (v_cnt_q == VW'(V_TOTAL - 1));
   assign boundary = !running || v_wrap;

   always_ff @(posedge clk_llc2 or negedge resetx) begin
      if (!resetx) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable)            state_d = ST_RUN;
         ST_RUN:  if (v_wrap && !enable) state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      running = (state_q == ST_RUN);
   end

   always_comb begin
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      odd_field_d = odd_field_q;
      if (!running) begin
         h_cnt_d     = '0;
         v_cnt_d     = '0;
         odd_field_d = 1'b1;
      end else if (h_wrap) begin
         h_cnt_d = '0;
         if (v_wrap) begin
            v_cnt_d     = '0;
            odd_field_d = ~odd_field_q;
         end else begin
            v_cnt_d = v_cnt_q + VW'(1);
         end
      end else begin
         h_cnt_d = h_cnt_q + HW'(1);
      end
   end

   always_ff @(posedge clk_llc2 or negedge resetx) begin
      if (!resetx) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         odd_field_q <= 1'b1;
         pat_q       <= PAT_BARS;
         fix_q       <= '0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         odd_field_q <= odd_field_d;
         // Pattern only changes between fields to avoid tearing
         if (boundary) begin
            pat_q <= pattern_e'(pattern_sel);
            fix_q <= fixed_rgb;
         end
      end
   end

   always_comb begin
      bar_idx = h_cnt_q / HW'(BAR_W);
      bar_sel = (bar_idx > HW'(7)) ? 3'd7 : bar_idx[2:0];
      ramp_g  = h_cnt_q[9:2];
      case (pat_q)
         PAT_BARS:  rgb0 = bar_rgb(bar_sel);
         PAT_RAMP:  rgb0 = {ramp_g[7:3], ramp_g[7:2], ramp_g[7:3]};
         PAT_FIXED: rgb0 = fix_q;
         default:   rgb0 = (h_cnt_q[4] ^ v_cnt_q[4]) ? 16'hFFFF : 16'h0000;
      endcase
      tim0.href = running && (h_cnt_q < HW'(H_ACTIVE));
      tim0.vref = running && (v_cnt_q < VW'(V_ACTIVE));
      tim0.odd  = running && odd_field_q;
      tim0.fs   = running && odd_field_q && (h_cnt_q == '0) && (v_cnt_q == '0);
      act0      = tim0.href && tim0.vref;
   end

   rgb565_to_ycbcr u_conv (
      .clk_llc2 (clk_llc2),
      .resetx   (resetx),
      .rgb_i    (rgb1_q),
      .y_o      (y2),
      .cb_o     (cb2),
      .cr_o     (cr2)
   );

   // 4:2:2 packing: chroma pair comes from the even pixel only
   always_comb begin
      vpo_d     = BLACK_YC;
      cr_held_d = cr_held_q;
      if (act2_q) begin
         if (!x0_2_q) begin
            vpo_d     = {y2, cb2};
            cr_held_d = cr2;
         end else begin
            vpo_d = {y2, cr_held_q};
         end
      end
   end

   always_ff @(posedge clk_llc2 or negedge resetx) begin
      if (!resetx) begin
         rgb1_q    <= '0;
         tim1_q    <= '0;
         act1_q    <= 1'b0;
         x0_1_q    <= 1'b0;
         tim2_q    <= '0;
         act2_q    <= 1'b0;
         x0_2_q    <= 1'b0;
         tim3_q    <= '0;
         cr_held_q <= 8'd128;
         vpo_q     <= BLACK_YC;
      end else begin
         rgb1_q    <= rgb0;
         tim1_q    <= tim0;
         act1_q    <= act0;
         x0_1_q    <= h_cnt_q[0];
         tim2_q    <= tim1_q;
         act2_q    <= act1_q;
         x0_2_q    <= x0_1_q;
         tim3_q    <= tim2_q;
         cr_held_q <= cr_held_d;
         vpo_q     <= vpo_d;
      end
   end

   assign href        = tim3_q.href;
   assign vref        = tim3_q.vref;
   assign odd         = tim3_q.odd;
   assign frame_start = tim3_q.fs;
   assign vpo         = vpo_q;

endmodule

// File: tb/tb_ycbcr_video_source.sv
// Bench for ycbcr_video_source: small-timing instance against a scoreboard model, full-size instance for bars.
module tb_ycbcr_video_source;

   logic        clk_llc2 = 1'b0;
   logic        resetx   = 1'b0;
   logic        en_s = 1'b0, en_f = 1'b0;
   logic [1:0]  pat_s = 2'd2, pat_f = 2'd0;
   logic [15:0] fix_s = 16'hFFFF, fix_f = 16'h0000;
   logic        href_s, vref_s, odd_s, fs_s;
   logic        href_f, vref_f, odd_f, fs_f;
   logic [15:0] vpo_s, vpo_f;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        href;
      logic        vref;
      logic        odd;
      logic        fs;
      logic [15:0] vpo;
   } obs_t;

   obs_t exp_q[$];

   int          m_h = 0, m_v = 0;
   logic        m_odd = 1'b1, m_run = 1'b0;
   logic [1:0]  m_pat = 2'd2;
   logic [15:0] m_fix = 16'hFFFF;

   always #5 clk_llc2 = ~clk_llc2;

   ycbcr_video_source #(
      .H_TOTAL(16), .H_ACTIVE(8), .V_TOTAL(6), .V_ACTIVE(4)
   ) dut_s (
      .clk_llc2(clk_llc2), .resetx(resetx), .enable(en_s), .pattern_sel(pat_s),
      .fixed_rgb(fix_s), .href(href_s), .vref(vref_s), .odd(odd_s), .vpo(vpo_s),
      .frame_start(fs_s)
   );

   ycbcr_video_source dut_f (
      .clk_llc2(clk_llc2), .resetx(resetx), .enable(en_f), .pattern_sel(pat_f),
      .fixed_rgb(fix_f), .href(href_f), .vref(vref_f), .odd(odd_f), .vpo(vpo_f),
      .frame_start(fs_f)
   );

   // Reference YCbCr words for the colours used on the small instance (H_ACTIVE < BAR_W keeps bars white)
   function automatic logic [15:0] pix_yc(input logic [1:0] p, input logic [15:0] f, input logic x0);
      if (p == 2'd0) return 16'hEB80;
      case (f)
         16'hFFFF: return 16'hEB80;
         16'hF800: return x0 ? 16'h52F0 : 16'h525A;
         default:  return 16'h1080;
      endcase
   endfunction

   initial begin : sb_model
      obs_t e;
      forever begin
         @(posedge clk_llc2 or negedge resetx);
         if (!resetx) begin
            m_h = 0; m_v = 0; m_odd = 1'b1; m_run = 1'b0;
            m_pat = pat_s; m_fix = fix_s;
            exp_q.delete();
         end else begin
            e.href = m_run && (m_h < 8);
            e.vref = m_run && (m_v < 4);
            e.odd  = m_run && m_odd;
            e.fs   = m_run && m_odd && (m_h == 0) && (m_v == 0);
            e.vpo  = (e.href && e.vref) ? pix_yc(m_pat, m_fix, (m_h % 2) == 1) : 16'h1080;
            exp_q.push_back(e);
            if (!m_run) begin
               m_run = en_s; m_pat = pat_s; m_fix = fix_s;
            end else if (m_h == 15) begin
               m_h = 0;
               if (m_v == 5) begin
                  m_v = 0; m_odd = !m_odd; m_pat = pat_s; m_fix = fix_s;
                  if (!en_s) begin m_run = 1'b0; m_odd = 1'b1; end
               end else begin
                  m_v++;
               end
            end else begin
               m_h++;
            end
         end
      end
   end

   initial begin : sb_monitor
      obs_t e;
      forever begin
         @(negedge clk_llc2);
         if (resetx && exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            total++;
            if ({href_s, vref_s, odd_s, fs_s, vpo_s} !== e) begin
               bad++;
               $display("FAIL sb_stream t=%0t got=%h exp=%h", $time,
                        {href_s, vref_s, odd_s, fs_s, vpo_s}, e);
            end
         end
      end
   end

   task automatic test_reset();
      resetx = 1'b0; en_s = 1'b0; en_f = 1'b0;
      repeat (3) @(negedge clk_llc2);
      total++;
      if ({href_s, vref_s, odd_s, fs_s, vpo_s, href_f, vref_f, odd_f, fs_f, vpo_f}
          !== {4'b0, 16'h1080, 4'b0, 16'h1080}) begin
         bad++;
         $display("FAIL reset_values got_s=%h got_f=%h exp=01080", {href_s, vref_s, odd_s, fs_s, vpo_s},
                  {href_f, vref_f, odd_f, fs_f, vpo_f});
      end
      resetx = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_llc2);
         total++;
         if ({href_s, vref_s, odd_s, fs_s, vpo_s, href_f, vref_f, odd_f, fs_f, vpo_f}
             !== {4'b0, 16'h1080, 4'b0, 16'h1080}) begin
            bad++;
            $display("FAIL idle_hold cyc=%0d got_s=%h got_f=%h exp=01080", i,
                     {href_s, vref_s, odd_s, fs_s, vpo_s}, {href_f, vref_f, odd_f, fs_f, vpo_f});
         end
      end
   endtask

   task automatic test_timing();
      int n, href_bad, vref_bad, href_cnt, vref_cnt, fs_cnt, fs_bad;
      logic odd0, odd96, odd191, odd192;
      pat_s = 2'd2; fix_s = 16'hFFFF; en_s = 1'b1;
      n = 0;
      while (fs_s !== 1'b1 && n < 100) begin @(negedge clk_llc2); n++; end
      total++;
      if (fs_s !== 1'b1) begin bad++; $display("FAIL timing_first_fs got=%b exp=1", fs_s); end
      href_bad = 0; vref_bad = 0; href_cnt = 0; vref_cnt = 0; fs_cnt = 0; fs_bad = 0;
      odd0 = 1'bx; odd96 = 1'bx; odd191 = 1'bx; odd192 = 1'bx;
      for (int i = 0; i < 384; i++) begin
         if (href_s === 1'b1) href_cnt++;
         if (vref_s === 1'b1) vref_cnt++;
         if (href_s !== ((i % 16) < 8)) href_bad++;
         if (vref_s !== (((i / 16) % 6) < 4)) vref_bad++;
         if (fs_s === 1'b1) begin
            fs_cnt++;
            if ((i != 0 && i != 192) || href_s !== 1'b1) fs_bad++;
         end
         if (i == 0)   odd0   = odd_s;
         if (i == 96)  odd96  = odd_s;
         if (i == 191) odd191 = odd_s;
         if (i == 192) odd192 = odd_s;
         @(negedge clk_llc2);
      end
      total++; if (href_bad != 0) begin bad++; $display("FAIL href_shape got=%0d exp=0 bad cycles", href_bad); end
      total++; if (href_cnt != 192) begin bad++; $display("FAIL href_count got=%0d exp=192", href_cnt); end
      total++; if (vref_bad != 0) begin bad++; $display("FAIL vref_shape got=%0d exp=0 bad cycles", vref_bad); end
      total++; if (vref_cnt != 256) begin bad++; $display("FAIL vref_count got=%0d exp=256", vref_cnt); end
      total++; if (fs_cnt != 2 || fs_bad != 0) begin bad++; $display("FAIL fs_pulses got=%0d/%0d exp=2/0", fs_cnt, fs_bad); end
      total++;
      if ({odd0, odd96, odd191, odd192} !== 4'b1001) begin
         bad++; $display("FAIL odd_toggle got=%b exp=1001", {odd0, odd96, odd191, odd192});
      end
   endtask

   task automatic test_conversion();
      logic [15:0] fx [3];
      logic [15:0] ev [3];
      logic [15:0] od [3];
      int n;
      fx[0] = 16'hFFFF; ev[0] = 16'hEB80; od[0] = 16'hEB80;
      fx[1] = 16'h0000; ev[1] = 16'h1080; od[1] = 16'h1080;
      fx[2] = 16'hF800; ev[2] = 16'h525A; od[2] = 16'h52F0;
      pat_s = 2'd2;
      for (int k = 0; k < 3; k++) begin
         fix_s = fx[k];
         repeat (100) @(negedge clk_llc2);
         n = 0;
         while (fs_s !== 1'b1 && n < 200) begin @(negedge clk_llc2); n++; end
         total++;
         if (vpo_s !== ev[k]) begin bad++; $display("FAIL conv_even rgb=%h got=%h exp=%h", fx[k], vpo_s, ev[k]); end
         @(negedge clk_llc2);
         total++;
         if (vpo_s !== od[k]) begin bad++; $display("FAIL conv_odd rgb=%h got=%h exp=%h", fx[k], vpo_s, od[k]); end
      end
   endtask

   task automatic test_latch();
      int n;
      n = 0;
      while (fs_s !== 1'b1 && n < 250) begin @(negedge clk_llc2); n++; end
      total++;
      if (fs_s !== 1'b1) begin bad++; $display("FAIL latch_sync got=%b exp=1", fs_s); end
      repeat (40) @(negedge clk_llc2);
      pat_s = 2'd0;
      n = 0;
      while (!(href_s === 1'b1 && vref_s === 1'b1) && n < 50) begin @(negedge clk_llc2); n++; end
      total++;
      if (vpo_s !== 16'h525A) begin bad++; $display("FAIL latch_old got=%h exp=525a", vpo_s); end
      n = 0;
      while (vref_s !== 1'b0 && n < 100) begin @(negedge clk_llc2); n++; end
      n = 0;
      while (!(href_s === 1'b1 && vref_s === 1'b1) && n < 100) begin @(negedge clk_llc2); n++; end
      total++;
      if (vpo_s !== 16'hEB80) begin bad++; $display("FAIL latch_new got=%h exp=eb80", vpo_s); end
   endtask

   task automatic test_bars();
      int n, blank_bad, act_bad;
      pat_f = 2'd0; en_f = 1'b1;
      n = 0;
      while (href_f !== 1'b1 && n < 30) begin @(negedge clk_llc2); n++; end
      blank_bad = 0; act_bad = 0;
      for (int i = 0; i <= 858; i++) begin
         if (i == 0) begin
            total++;
            if (vpo_f !== 16'hEB80 || fs_f !== 1'b1) begin
               bad++; $display("FAIL bars_px0 got=%h fs=%b exp=eb80 fs=1", vpo_f, fs_f);
            end
         end
         if (i == 89) begin
            total++; if (vpo_f !== 16'hEB80) begin bad++; $display("FAIL bars_px89 got=%h exp=eb80", vpo_f); end
         end
         if (i == 90) begin
            total++; if (vpo_f !== 16'hD210) begin bad++; $display("FAIL bars_px90 got=%h exp=d210", vpo_f); end
         end
         if (i == 450) begin
            total++; if (vpo_f !== 16'h525A) begin bad++; $display("FAIL bars_px450 got=%h exp=525a", vpo_f); end
         end
         if (i == 451) begin
            total++; if (vpo_f !== 16'h52F0) begin bad++; $display("FAIL bars_px451 got=%h exp=52f0", vpo_f); end
         end
         if (i == 719) begin
            total++; if (vpo_f[15:8] !== 8'h10) begin bad++; $display("FAIL bars_px719_y got=%h exp=10", vpo_f[15:8]); end
         end
         if (i < 720 && href_f !== 1'b1) act_bad++;
         if (i >= 720 && i < 858 && (href_f !== 1'b0 || vpo_f !== 16'h1080)) blank_bad++;
         if (i == 858) begin
            total++;
            if (href_f !== 1'b1 || vpo_f !== 16'hEB80) begin
               bad++; $display("FAIL bars_line1 got=%b/%h exp=1/eb80", href_f, vpo_f);
            end
         end
         @(negedge clk_llc2);
      end
      total++; if (act_bad != 0) begin bad++; $display("FAIL bars_href_active got=%0d exp=0", act_bad); end
      total++; if (blank_bad != 0) begin bad++; $display("FAIL bars_hblank got=%0d exp=0", blank_bad); end
      en_f = 1'b0;
   endtask

   task automatic test_stop();
      int n, vcnt, idle_bad;
      n = 0;
      while (fs_s !== 1'b1 && n < 250) begin @(negedge clk_llc2); n++; end
      repeat (30) @(negedge clk_llc2);
      en_s = 1'b0;
      vcnt = 0;
      for (int k = 0; k < 110; k++) begin
         @(negedge clk_llc2);
         if (vref_s === 1'b1) vcnt++;
      end
      total++; if (vcnt != 33) begin bad++; $display("FAIL stop_field_completes got=%0d exp=33", vcnt); end
      idle_bad = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk_llc2);
         if ({href_s, vref_s, odd_s, fs_s, vpo_s} !== {4'b0, 16'h1080}) idle_bad++;
      end
      total++; if (idle_bad != 0) begin bad++; $display("FAIL stop_idle got=%0d exp=0", idle_bad); end
   endtask

   task automatic test_async_reset();
      int n;
      en_s = 1'b1; pat_s = 2'd2; fix_s = 16'hF800;
      n = 0;
      while (!(href_s === 1'b1 && vref_s === 1'b1) && n < 200) begin @(negedge clk_llc2); n++; end
      @(posedge clk_llc2);
      #2 resetx = 1'b0;
      #1;
      total++;
      if ({href_s, vref_s, odd_s, fs_s, vpo_s, href_f, vref_f, odd_f, fs_f, vpo_f}
          !== {4'b0, 16'h1080, 4'b0, 16'h1080}) begin
         bad++;
         $display("FAIL async_reset got_s=%h got_f=%h exp=01080", {href_s, vref_s, odd_s, fs_s, vpo_s},
                  {href_f, vref_f, odd_f, fs_f, vpo_f});
      end
      repeat (2) @(negedge clk_llc2);
      resetx = 1'b1;
      n = 0;
      while (fs_s !== 1'b1 && n < 20) begin @(negedge clk_llc2); n++; end
      total++;
      if (fs_s !== 1'b1 || vpo_s !== 16'h525A) begin
         bad++; $display("FAIL restart_fs got=%b/%h exp=1/525a", fs_s, vpo_s);
      end
      repeat (300) @(negedge clk_llc2);
   endtask

   initial begin
      test_reset();
      test_timing();
      test_conversion();
      test_latch();
      test_bars();
      test_stop();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ycbcr_video_source.md
Name: ycbcr_video_source

Overview:
- Synthetic SAA7111A-style video transmitter; the sending end of the capture interface (vref/href/odd/vpo) consumed by the FPGA image-capture path.
- Generates interlaced field timing at 13.5 MHz and a selectable RGB565 test pattern.
- Converts each pixel to YCbCr 4:2:2 on a 16-bit bus.
- Used for board bring-up and closed-loop capture tests without a camera.

Parameters:
- H_TOTAL, 858, clocks per line.
- H_ACTIVE, 720, active pixels per line (even).
- V_TOTAL, 262, lines per field.
- V_ACTIVE, 240, active lines per field.
- BAR_W, 90, colour-bar width in pixels (8 bars).

Ports:
- clk_llc2  in  1  13.5 MHz pixel clock.
- resetx  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- pattern_sel  in  2  0=colour bars, 1=grey ramp, 2=fixed colour, 3=checker.
- fixed_rgb  in  16  RGB565 colour for pattern 2.
- href  out  1  active-pixel window.
- vref  out  1  active-line window.
- odd  out  1  field flag (1 = first field).
- vpo  out  16  [15:8]=Y, [7:0]=Cb on even pixels, Cr on odd pixels.
- frame_start  out  1  one-cycle pulse on the first output pixel of an odd field.

Behaviour:
- Reset: h_cnt=0, v_cnt=0, odd_i=1, running=0, pipeline cleared. Outputs: href=0, vref=0, odd=0, frame_start=0, vpo=16'h1080 (black).
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - At the h wrap, v_cnt increments, running 0..V_TOTAL-1.
  - At the v wrap, odd_i toggles.
- Raw windows: href_r = (h_cnt<H_ACTIVE); vref_r = (v_cnt<V_ACTIVE).
- Start/stop:
  - running is set when enable=1 at a field boundary (h=0, v=0, or while idle).
  - When enable drops, the current field completes; running clears at the next v wrap.
  - Idle: counters held at 0, odd_i=1, windows forced 0, vpo=16'h1080.
- pattern_sel and fixed_rgb are latched at each field boundary, so there is no tearing mid-field.
- Pixel generation (stage 0), x = h_cnt:
  - Bars: index = x/BAR_W, clamped to 7. Colours: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Ramp: g = x[9:2]; rgb = {g[7:3], g[7:2], g[7:3]}.
  - Checker: FFFF if x[4]^v_cnt[4], else 0000.
- Expansion: 565 to 888 by bit replication (R8={R5,R5[4:2]}, G8={G6,G6[5:4]}).
- Stage 1 (signed 18-bit products):
  - Y  = ((66R+129G+25B+128)>>>8)+16
  - Cb = ((-38R-74G+112B+128)>>>8)+128
  - Cr = ((112R-94G-18B+128)>>>8)+128
  - Shifts are arithmetic (floor). Each result is clamped to 0..255.
- Stage 2, 4:2:2 packing:
  - Even x: vpo={Y,Cb}; Cr of that pixel is held.
  - Odd x: vpo={Y,Cr_held}.
  - Chroma is taken from the even pixel only.
- Outside href_r or vref_r, vpo=16'h1080.
- Latency: href, vref, odd, frame_start and vpo are all delayed 3 clk_llc2 cycles from the counters. The timing outputs stay exactly aligned with vpo.
- odd output = odd_i & running (delayed).
- frame_start = running & odd_i & h=0 & v=0 (delayed). Exactly one pulse per frame (two fields).
- Async reset mid-line immediately returns all outputs to reset values. After release, a new field starts when enable=1.

Decomposition:
- Shared package holds:
  - pattern encodings (PAT_BARS, PAT_RAMP, PAT_FIXED, PAT_CHECK);
  - the eight bar RGB565 constants;
  - BLACK_YC = 16'h1080;
  - conversion coefficients.
- One sub-module, rgb565_to_ycbcr: a 1-cycle registered converter (RGB565 in; Y, Cb, Cr out, clamped).
- Timing, pattern and 4:2:2 packing live in the top module.

Test Plan:
- Reset/idle (enable=0): after resetx release, href=vref=odd=0 and vpo=16'h1080 for 2000 cycles.
- Timing, sim parameters H_TOTAL=16, H_ACTIVE=8, V_TOTAL=6, V_ACTIVE=4, enable=1:
  - href is high 8 of every 16 cycles;
  - vref is high 4 of every 6 lines;
  - odd alternates each 96 cycles;
  - frame_start is a single pulse every 192 cycles, coincident with the first href.
- Conversion, pattern_sel=2:
  - fixed_rgb=FFFF: vpo alternates 16'hEB80, 16'hEB80.
  - fixed_rgb=F800: vpo alternates 16'h525A, 16'h52F0.
  - fixed_rgb=0000: vpo 16'h1080.
- Bars, default parameters: pixel 0 gives Y=235; pixel 450 (red) gives Y=82, Cb=90; pixel 719 (black) gives Y=16. Output is 16'h1080 at h=720..857.
- Field-boundary latching: change pattern_sel mid-field. The remainder of that field keeps the old pattern; the new pattern appears exactly at the next field's first pixel.
- Stop/reset:
  - Drop enable mid-field: the field completes, then vref stays 0 and odd=0.
  - Assert resetx mid-line: all outputs are at reset values before the next clock edge.
